reg_cmd_parser: RTL and testbench
=================================

REG_CMD_PARSER -- requirements
Module: reg_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hAA: command frame start marker.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 64: maximum cycles to wait for reg_ack.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_data, input, 8: command byte from the host FIFO reader.
REQ-006 SHALL have port cmd_valid, input, 1: cmd_data is valid.
REQ-007 SHALL have port cmd_ready, output, 1: parser accepts a byte this cycle.
REQ-008 SHALL have port reg_addr, output, 16: register address.
REQ-009 SHALL have port reg_wdata, output, 32: register write value.
REQ-010 SHALL have port reg_wr, output, 1: transaction is a write (1) or a read (0).
REQ-011 SHALL have port reg_req, output, 1: one-cycle transaction strobe.
REQ-012 SHALL have port reg_ack, input, 1: register bank completion.
REQ-013 SHALL have port reg_rdata, input, 32: register value, sampled when reg_ack is 1.
REQ-014 SHALL have port reply_data, output, 8: reply byte to the host FIFO writer.
REQ-015 SHALL have port reply_valid, output, 1: reply_data is valid.
REQ-016 SHALL have port reply_ready, input, 1: downstream accepts the reply byte.
REQ-017 SHALL have port timeout_count, output, 8: saturating count of ack timeouts.

Function
REQ-018 SHALL transfer a byte only on a clk edge where cmd_valid and cmd_ready are both 1; cmd_ready is 1 only in SYNC and COLLECT.
REQ-019 SHALL use the states SYNC, COLLECT, ISSUE, WAIT_ACK and REPLY.
REQ-020 In SYNC, SHALL discard every accepted byte other than SYNC_BYTE; on SYNC_BYTE it SHALL clear the byte index and go to COLLECT.
REQ-021 In COLLECT, SHALL take 7 bytes in this order: write flag (bit0 only, bits 7:1 ignored), addr[7:0], addr[15:8], value[7:0], value[15:8], value[23:16], value[31:24].
REQ-022 After the 7th byte, SHALL enter ISSUE and drive reg_req=1 for exactly one cycle with reg_addr/reg_wdata/reg_wr stable, then enter WAIT_ACK.
REQ-023 SHALL hold reg_addr, reg_wdata and reg_wr stable from ISSUE until WAIT_ACK exits.
REQ-024 In WAIT_ACK, on reg_ack=1 SHALL latch reg_rdata and enter REPLY; an ack arriving in the same cycle as reg_req SHALL be ignored.
REQ-025 If reg_ack is not seen within ACK_TIMEOUT cycles of entering WAIT_ACK, SHALL latch 32'hFFFFFFFF as the reply, increment timeout_count (saturating at 255) and enter REPLY.
REQ-026 In REPLY, SHALL present 4 bytes LSB first (rdata[7:0] first); each byte SHALL be held until reply_ready=1, then SHALL advance; after the 4th accepted byte SHALL return to SYNC.
REQ-027 SHALL reply to writes as well as reads, returning reg_rdata as acknowledged by the register bank.
REQ-028 A SYNC_BYTE value received in COLLECT SHALL be treated as data, not as a resync.
REQ-029 Total latency, from the last command byte accepted to the first reply_valid, SHALL be (ack cycles)+2 when reply_ready is held at 1.
REQ-030 reg_ack asserted outside WAIT_ACK SHALL be ignored.

Reset
REQ-031 While reset_n=0, SHALL be in SYNC with cmd_ready=1, reg_req=0, reg_wr=0, reg_addr=0, reg_wdata=0, reply_valid=0, reply_data=0, timeout_count=0.
REQ-032 Reset asserted mid-frame or mid-reply SHALL abandon the frame immediately; no partial reply byte SHALL follow deassertion.

Structure
REQ-033 SYNC_BYTE, the state encoding and the frame length (8 bytes) SHALL live in a shared package used by the host-side command fixture.
REQ-034 The block SHALL be a single module; the timeout counter stays inline, with no sub-module.

Verification
REQ-035 Bytes FF FF FF, then a read of addr 0001 -> no reg_req for the FF bytes; one reg_req with reg_addr=0001, reg_wr=0; reply bytes equal to the reg_rdata bytes, LSB first.
REQ-036 Frame AA 01 03 00 04 00 00 00 -> reg_req with reg_wr=1, reg_addr=0003, reg_wdata=00000004; 4 reply bytes follow.
REQ-037 Bank that never acks, ACK_TIMEOUT=64 -> reply FF FF FF FF 64 cycles after reg_req; timeout_count=1.
REQ-038 reply_ready held low for 10 cycles during byte 2 -> reply_data stable and no byte lost or duplicated; cmd_ready=0 throughout.
REQ-039 reset_n pulsed low after 4 command bytes, then a full read frame -> exactly one transaction, on the new frame's address.
REQ-040 Frame with value bytes AA AA AA AA -> reg_wdata=AAAAAAAA; no resync.

Source files
------------

// File: rtl/reg_cmd_parser_pkg.sv
// Shared framing constants, state encoding and command bundle
// for the register command parser and its host-side fixture.
package reg_cmd_parser_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
    localparam int         FRAME_LEN     = 8;
    localparam int         BODY_LEN      = FRAME_LEN - 1;
    localparam int         REPLY_LEN     = 4;

    localparam logic [2:0] ST_SYNC     = 3'd0;
    localparam logic [2:0] ST_COLLECT  = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_REPLY    = 3'd4;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } reg_cmd_t;

    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  sel
    );
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/reg_cmd_parser.sv
// Byte-stream command parser: frames host bytes into a register
// transaction, waits for the bank ack and streams a 4-byte reply.
module reg_cmd_parser
    import reg_cmd_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_req,
    input  logic        reg_ack,
    input  logic [31:0] reg_rdata,
    output logic [7:0]  reply_data,
    output logic        reply_valid,
    input  logic        reply_ready,
    output logic [7:0]  timeout_count
);

    localparam int            WW        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(BODY_LEN - 1);
    localparam logic [1:0]    RB_LAST   = 2'(REPLY_LEN - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    reg_cmd_t      cmd_q, cmd_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rb_q, rb_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic          accept;

    assign cmd_ready = (state_q == ST_SYNC) || (state_q == ST_COLLECT);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        rb_d    = rb_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            ST_SYNC: begin
                if (accept && (cmd_data == SYNC_BYTE)) begin
                    idx_d   = 3'd0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A SYNC_BYTE here is payload, never a resync.
                if (accept) begin
                    case (idx_q)
                        3'd0:    cmd_d.wr           = cmd_data[0];
                        3'd1:    cmd_d.addr[7:0]    = cmd_data;
                        3'd2:    cmd_d.addr[15:8]   = cmd_data;
                        3'd3:    cmd_d.wdata[7:0]   = cmd_data;
                        3'd4:    cmd_d.wdata[15:8]  = cmd_data;
                        3'd5:    cmd_d.wdata[23:16] = cmd_data;
                        default: cmd_d.wdata[31:24] = cmd_data;
                    endcase
                    idx_d = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wait_d  = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (reg_ack) begin
                    rdata_d = reg_rdata;
                    rb_d    = 2'd0;
                    state_d = ST_REPLY;
                end else if (wait_q == WAIT_LAST) begin
                    rdata_d = 32'hFFFF_FFFF;
                    rb_d    = 2'd0;
                    state_d = ST_REPLY;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_REPLY: begin
                if (reply_ready) begin
                    rb_d = rb_q + 2'd1;
                    if (rb_q == RB_LAST) begin
                        state_d = ST_SYNC;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SYNC;
            idx_q   <= '0;
            cmd_q   <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            rb_q    <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            rb_q    <= rb_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign reg_req       = (state_q == ST_ISSUE);
    assign reg_addr      = cmd_q.addr;
    assign reg_wdata     = cmd_q.wdata;
    assign reg_wr        = cmd_q.wr;
    assign reply_valid   = (state_q == ST_REPLY);
    assign reply_data    = reply_valid ? word_byte(rdata_q, rb_q) : 8'h00;
    assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_reg_cmd_parser.sv
// Bench for reg_cmd_parser: frame-level scoreboard, reactive bank
// model and per-cycle output checks against directed frames.
module tb_reg_cmd_parser;
    import reg_cmd_parser_pkg::*;

    localparam int ATO = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_req;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic [7:0]  reply_data;
    logic        reply_valid;
    logic        reply_ready;
    logic [7:0]  timeout_count;

    reg_cmd_parser #(
        .SYNC_BYTE   (8'hAA),
        .ACK_TIMEOUT (ATO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_wr        (reg_wr),
        .reg_req       (reg_req),
        .reg_ack       (reg_ack),
        .reg_rdata     (reg_rdata),
        .reply_data    (reply_data),
        .reply_valid   (reply_valid),
        .reply_ready   (reply_ready),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc;
    int n_sent;
    int n_done;
    int last_cyc;
    int exp_lat;
    int bank_delay;
    int bank_cnt;
    int spur_until;
    bit bank_early;
    logic [31:0] bank_word;
    reg_cmd_t    exp_txn[$];
    logic [7:0]  exp_reply[$];
    logic [31:0] mem[logic [15:0]];
    logic        last_wr;
    logic [15:0] last_addr;
    logic [31:0] last_wdata;
    logic [31:0] last_reply;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Register bank: acks bank_delay cycles into WAIT_ACK, or never.
    initial begin : bank
        reg_ack   = 1'b0;
        reg_rdata = '0;
        bank_cnt  = -1;
        forever begin
            @(negedge clk);
            reg_ack = 1'b0;
            if (!reset_n) begin
                bank_cnt = -1;
            end else if (cyc < spur_until) begin
                reg_ack   = 1'b1;
                reg_rdata = 32'h5A5A_5A5A;
            end else if (bank_cnt == 0) begin
                reg_ack   = 1'b1;
                reg_rdata = bank_word;
                for (int i = 0; i < 4; i++)
                    exp_reply.push_back(bank_word[8*i +: 8]);
                bank_cnt = -1;
            end else if (bank_cnt > 0) begin
                bank_cnt--;
            end else if (reg_req) begin
                if (bank_early) begin
                    reg_ack   = 1'b1;
                    reg_rdata = 32'hBAD0_BAD0;
                end
                if (bank_delay < 0)
                    for (int i = 0; i < 4; i++) exp_reply.push_back(8'hFF);
                bank_cnt = bank_delay;
            end
        end
    end

    initial begin : cmp
        logic [31:0] asm_w;
        logic [48:0] held;
        logic [7:0]  prev_data;
        logic [7:0]  eb;
        reg_cmd_t    t;
        bit          in_txn;
        bit          stall;
        bit          lat_seen;
        int          rcount;
        cyc = 0; n_done = 0; in_txn = 0; stall = 0;
        lat_seen = 1; rcount = 0; asm_w = '0; held = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!reset_n) begin
                check("rst_ctl", {cmd_ready, reg_req, reg_wr, reply_valid}, 4'b1000);
                check("rst_addr", reg_addr, 0);
                check("rst_wdata", reg_wdata, 0);
                check("rst_reply_data", reply_data, 0);
                check("rst_tcnt", timeout_count, 0);
                exp_reply.delete();
                n_done = n_sent; in_txn = 0; stall = 0; rcount = 0; lat_seen = 1;
            end else begin
                check("cmd_ready", cmd_ready, n_sent == n_done);
                if (n_sent == n_done) check("reply_idle", reply_valid, 0);
                if (reg_req) begin
                    lat_seen = 0;
                    if (exp_txn.size() == 0) begin
                        check("unexpected_req", reg_req, 0);
                    end else begin
                        t = exp_txn.pop_front();
                        check("req_wr", reg_wr, t.wr);
                        check("req_addr", reg_addr, t.addr);
                        check("req_wdata", reg_wdata, t.wdata);
                        last_wr = reg_wr; last_addr = reg_addr; last_wdata = reg_wdata;
                        held = {reg_wr, reg_addr, reg_wdata};
                        in_txn = 1;
                    end
                end else if (in_txn && !reply_valid) begin
                    check("req_hold", {reg_wr, reg_addr, reg_wdata}, held);
                end
                if (reply_valid) begin
                    in_txn = 0;
                    if (!lat_seen) begin
                        check("latency", cyc - 1 - last_cyc, exp_lat);
                        lat_seen = 1;
                    end
                    if (stall) check("reply_stall_hold", reply_data, prev_data);
                    stall = !reply_ready;
                    prev_data = reply_data;
                    if (reply_ready) begin
                        if (exp_reply.size() == 0) begin
                            check("unexpected_reply", reply_valid, 0);
                        end else begin
                            eb = exp_reply.pop_front();
                            check("reply_byte", reply_data, eb);
                        end
                        asm_w = {reply_data, asm_w[31:8]};
                        rcount++;
                        if (rcount == 4) begin
                            rcount = 0; last_reply = asm_w; n_done++;
                        end
                    end
                end else begin
                    stall = 0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
    endtask

    // delay < 0: bank never acks
    task automatic do_cmd(input logic [7:0] flag, input logic [15:0] addr,
                          input logic [31:0] val, input int delay,
                          input bit early);
        logic [7:0] fr[FRAME_LEN];
        fr[0] = SYNC_BYTE_DEF;
        fr[1] = flag;
        fr[2] = addr[7:0];
        fr[3] = addr[15:8];
        for (int i = 0; i < 4; i++) fr[4+i] = val[8*i +: 8];
        if (delay < 0) bank_word = 32'hFFFF_FFFF;
        else if (flag[0]) begin
            bank_word = val;
            mem[addr] = val;
        end else if (mem.exists(addr)) bank_word = mem[addr];
        else bank_word = {16'hC0DE, addr};
        bank_delay = delay;
        bank_early = early;
        exp_lat = (delay < 0) ? ATO + 1 : delay + 2;
        exp_txn.push_back('{wr: flag[0], addr: addr, wdata: val});
        for (int i = 0; i < FRAME_LEN; i++) send_byte(fr[i]);
        last_cyc = cyc;
        n_sent++;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (n_sent != n_done && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", n_sent == n_done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_reply_valid();
        int t = 0;
        while (!reply_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reply_valid_wait", reply_valid, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        cmd_data = '0; cmd_valid = 1'b0; reply_ready = 1'b1;
        bank_delay = 0; bank_early = 0; bank_word = '0;
        spur_until = 0; n_sent = 0; exp_lat = 0; last_cyc = 0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Garbage before sync, then a read of an untouched register
        repeat (3) send_byte(8'hFF);
        do_cmd(8'h00, 16'h0001, 32'h0, 0, 0);
        wait_idle();
        check("rd1_addr", last_addr, 16'h0001);
        check("rd1_wr", last_wr, 0);
        check("rd1_reply", last_reply, 32'hC0DE_0001);

        do_cmd(8'h01, 16'h0003, 32'h0000_0004, 2, 0);
        wait_idle();
        check("wr3_wr", last_wr, 1);
        check("wr3_addr", last_addr, 16'h0003);
        check("wr3_wdata", last_wdata, 32'h0000_0004);
        check("wr3_reply", last_reply, 32'h0000_0004);

        // Only bit0 of the flag byte selects write
        do_cmd(8'hFE, 16'h0003, 32'h1234_5678, 5, 0);
        wait_idle();
        check("fe_wr", last_wr, 0);
        check("fe_reply", last_reply, 32'h0000_0004);

        do_cmd(8'h01, 16'hAA55, 32'hAAAA_AAAA, 1, 0);
        wait_idle();
        check("aa_wdata", last_wdata, 32'hAAAA_AAAA);
        check("aa_addr", last_addr, 16'hAA55);

        do_cmd(8'h00, 16'h00AA, 32'h0, -1, 0);
        wait_idle();
        check("to_reply", last_reply, 32'hFFFF_FFFF);
        check("to_count1", timeout_count, 1);

        // Ack coinciding with reg_req must be ignored
        do_cmd(8'h00, 16'hAA55, 32'h0, 3, 1);
        bank_early = 0;
        wait_idle();
        check("early_reply", last_reply, 32'hAAAA_AAAA);

        spur_until = cyc + 5;
        repeat (8) @(negedge clk);
        check("spur_tcnt", timeout_count, 1);
        do_cmd(8'h00, 16'h0003, 32'h0, ATO - 1, 0);
        wait_idle();
        check("late_ack_reply", last_reply, 32'h0000_0004);
        check("late_ack_tcnt", timeout_count, 1);

        // Hold reply_ready low across the second reply byte
        do_cmd(8'h00, 16'h0001, 32'h0, 0, 0);
        wait_reply_valid();
        @(negedge clk);
        reply_ready = 1'b0;
        repeat (10) @(negedge clk);
        reply_ready = 1'b1;
        wait_idle();
        check("stall_reply", last_reply, 32'hC0DE_0001);

        for (int i = 0; i < 254; i++) begin
            do_cmd(8'h00, 16'(i), 32'h0, -1, 0);
            wait_idle();
        end
        check("tcnt_255", timeout_count, 255);
        do_cmd(8'h00, 16'h0100, 32'h0, -1, 0);
        wait_idle();
        check("tcnt_sat", timeout_count, 255);

        // Reset part-way through a frame
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h00);
        do_reset();
        check("rst_tcnt_clear", timeout_count, 0);
        do_cmd(8'h00, 16'hAA55, 32'h0, 0, 0);
        wait_idle();
        check("post_rst_addr", last_addr, 16'hAA55);
        check("post_rst_reply", last_reply, 32'hAAAA_AAAA);

        // Reset part-way through a reply
        reply_ready = 1'b0;
        do_cmd(8'h00, 16'h0003, 32'h0, 0, 0);
        wait_reply_valid();
        repeat (2) @(negedge clk);
        do_reset();
        reply_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_reply_gone", reply_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        check("txn_queue_empty", exp_txn.size(), 0);
        check("reply_queue_empty", exp_reply.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
